// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator with valid/ready handshake on both sides.
// Define IMM_GEN_PIPE_SKID_EN for a 2-entry skid buffer with registered in_ready.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_instr,
  input  logic [2:0]       in_immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  // in_instr holds instruction bits [31:7], so instruction bit k is ins[k-7].
  function automatic logic [XLEN-1:0] gen_imm(input logic [24:0] ins, input logic [2:0] src);
    logic [63:0] r;
    r = 64'h0;
    case (src)
      3'b000:  r = {{52{ins[24]}}, ins[24:13]};
      3'b001:  r = {{52{ins[24]}}, ins[24:18], ins[4:0]};
      3'b010:  r = {{51{ins[24]}}, ins[24], ins[0], ins[23:18], ins[4:1], 1'b0};
      3'b011:  r = {{43{ins[24]}}, ins[24], ins[12:5], ins[13], ins[23:14], 1'b0};
      3'b100:  r = {{32{ins[24]}}, ins[24:5], 12'h000};
      3'b101:  r = (XLEN == 64) ? {58'h0, ins[18:13]} : {59'h0, ins[17:13]};
      3'b110:  r = {59'h0, ins[12:8]};
      default: r = 64'h0;
    endcase
    return r[XLEN-1:0];
  endfunction

  function automatic logic gen_err(input logic [2:0] src);
    return (src == 3'b111);
  endfunction

  logic [XLEN-1:0]  in_imm_s;
  logic             in_err_s;
  logic             in_xfer_s;
  logic             out_xfer_s;
  logic             out_valid_r;
  logic [XLEN-1:0]  out_imm_r;
  logic             out_err_r;
  logic [TAG_W-1:0] out_tag_r;

  assign in_imm_s   = gen_imm(in_instr, in_immsrc);
  assign in_err_s   = gen_err(in_immsrc);
  assign in_xfer_s  = in_valid && in_ready;
  assign out_xfer_s = out_valid_r && out_ready;
  assign out_valid  = out_valid_r;
  assign out_imm    = out_imm_r;
  assign out_err    = out_err_r;
  assign out_tag    = out_tag_r;

`ifdef IMM_GEN_PIPE_SKID_EN
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_TWO   = 2'b10;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic             in_ready_r;
  logic [XLEN-1:0]  skid_imm_r;
  logic             skid_err_r;
  logic [TAG_W-1:0] skid_tag_r;

  assign in_ready = in_ready_r && !flush;

  // Occupancy next-state.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: state_nxt_s = in_xfer_s ? ST_ONE : ST_EMPTY;
        ST_ONE: begin
          if (in_xfer_s && !out_xfer_s) begin
            state_nxt_s = ST_TWO;
          end else if (!in_xfer_s && out_xfer_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_TWO:   state_nxt_s = out_xfer_s ? ST_ONE : ST_TWO;
        default:  state_nxt_s = ST_EMPTY;
      endcase
    end
  end

  // Head and skid registers; the skid slot only fills when the head is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_imm_r   <= '0;
      out_err_r   <= 1'b0;
      out_tag_r   <= '0;
      skid_imm_r  <= '0;
      skid_err_r  <= 1'b0;
      skid_tag_r  <= '0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s != ST_TWO);
      out_valid_r <= (state_nxt_s != ST_EMPTY);
      if (!flush) begin
        if (state_r == ST_TWO && out_xfer_s) begin
          out_imm_r <= skid_imm_r;
          out_err_r <= skid_err_r;
          out_tag_r <= skid_tag_r;
        end else if (in_xfer_s && (state_r == ST_EMPTY || out_xfer_s)) begin
          out_imm_r <= in_imm_s;
          out_err_r <= in_err_s;
          out_tag_r <= in_tag;
        end
        if (in_xfer_s && state_r == ST_ONE && !out_xfer_s) begin
          skid_imm_r <= in_imm_s;
          skid_err_r <= in_err_s;
          skid_tag_r <= in_tag;
        end
      end
    end
  end
`else
  assign in_ready = !flush && (!out_valid_r || out_ready);

  // Single output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_imm_r   <= '0;
      out_err_r   <= 1'b0;
      out_tag_r   <= '0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (in_xfer_s) begin
      out_valid_r <= 1'b1;
      out_imm_r   <= in_imm_s;
      out_err_r   <= in_err_s;
      out_tag_r   <= in_tag;
    end else if (out_xfer_s) begin
      out_valid_r <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances driven in lockstep.
module tb_imm_gen_pipe;

`ifdef IMM_GEN_PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [24:0] in_instr;
  logic [2:0]  in_immsrc;
  logic [4:0]  in_tag;

  logic        rdy32, vld32, err32;
  logic [31:0] imm32;
  logic [4:0]  tag32;
  logic        rdy64, vld64, err64;
  logic [63:0] imm64;
  logic [4:0]  tag64;

  typedef struct {
    logic [63:0] i32;
    logic [63:0] i64;
    logic        err;
    logic [4:0]  tag;
  } ent_t;

  ent_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cur;
  bit   acc;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag), .out_valid(vld32),
    .out_ready(out_ready), .out_imm(imm32), .out_err(err32), .out_tag(tag32));

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag), .out_valid(vld64),
    .out_ready(out_ready), .out_imm(imm64), .out_err(err64), .out_tag(tag64));

  function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] src, input bit x64);
    longint      s, t;
    logic [63:0] v;
    s = $signed(w);
    t = s >>> 31;
    case (src)
      3'd0: v = s >>> 20;
      3'd1: begin t = s >>> 25; v = (t << 5) | 64'(w[11:7]); end
      3'd2: v = (t << 12) | (64'(w[7]) << 11) | (64'(w[30:25]) << 5) | (64'(w[11:8]) << 1);
      3'd3: v = (t << 20) | (64'(w[19:12]) << 12) | (64'(w[20]) << 11) | (64'(w[30:21]) << 1);
      3'd4: v = s & ~64'hFFF;
      3'd5: v = x64 ? 64'(w[25:20]) : 64'(w[24:20]);
      3'd6: v = 64'(w[19:15]);
      default: v = 64'h0;
    endcase
    if (!x64) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs();
    chk("rst_valid32", 64'(vld32), 64'h0);
    chk("rst_valid64", 64'(vld64), 64'h0);
    chk("rst_imm32", 64'(imm32), 64'h0);
    chk("rst_imm64", imm64, 64'h0);
    chk("rst_err", {62'h0, err32, err64}, 64'h0);
    chk("rst_tag", {54'h0, tag32, tag64}, 64'h0);
  endtask

  // One cycle: drive at negedge, check model vs DUT, then advance model at posedge.
  task automatic step(input bit v, input logic [31:0] w, input logic [2:0] src, input logic [4:0] tg,
                      input bit ordy, input bit fl, output bit accepted,
                      input bit use_c = 1'b0, input logic [63:0] c32 = 64'h0, input logic [63:0] c64 = 64'h0);
    bit   exp_rdy;
    ent_t e;
    @(negedge clk);
    in_valid  = v;
    in_instr  = w[31:7];
    in_immsrc = src;
    in_tag    = tg;
    out_ready = ordy;
    flush     = fl;
    #1;
    exp_rdy = !fl && ((CAP == 2) ? (q.size() < 2) : (q.size() == 0 || ordy));
    chk("in_ready32", 64'(rdy32), 64'(exp_rdy));
    chk("in_ready64", 64'(rdy64), 64'(exp_rdy));
    chk("out_valid32", 64'(vld32), 64'(q.size() > 0));
    chk("out_valid64", 64'(vld64), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("imm32", 64'(imm32), q[0].i32);
      chk("imm64", imm64, q[0].i64);
      chk("err", {62'h0, err32, err64}, {62'h0, q[0].err, q[0].err});
      chk("tag", {54'h0, tag32, tag64}, {54'h0, q[0].tag, q[0].tag});
    end
    @(posedge clk);
    accepted = v && exp_rdy;
    if (fl) begin
      q.delete();
    end else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (accepted) begin
        e.i32 = use_c ? c32 : ref_imm(w, src, 1'b0);
        e.i64 = use_c ? c64 : ref_imm(w, src, 1'b1);
        e.err = (src == 3'b111);
        e.tag = tg;
        q.push_back(e);
      end
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 25'h0; in_immsrc = 3'h0; in_tag = 5'h0;
    #2;
    chk_zero_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Directed formats with constant expectations.
    step(1'b1, 32'hFFF00093, 3'd0, 5'd1, 1'b1, 1'b0, acc, 1'b1, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    step(1'b1, 32'hFE000E23, 3'd1, 5'd2, 1'b1, 1'b0, acc, 1'b1, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
    step(1'b1, 32'h00000463, 3'd2, 5'd3, 1'b1, 1'b0, acc, 1'b1, 64'h8, 64'h8);
    step(1'b1, 32'hFFDFF06F, 3'd3, 5'd4, 1'b1, 1'b0, acc, 1'b1, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
    step(1'b1, 32'h12345678, 3'd7, 5'd5, 1'b1, 1'b0, acc, 1'b1, 64'h0, 64'h0);
    step(1'b1, 32'h800000B7, 3'd4, 5'd6, 1'b1, 1'b0, acc, 1'b1, 64'h80000000, 64'hFFFFFFFF80000000);
    step(1'b1, 32'h03F09093, 3'd5, 5'd7, 1'b1, 1'b0, acc, 1'b1, 64'h1F, 64'h3F);
    step(1'b1, 32'h000F8073, 3'd6, 5'd8, 1'b1, 1'b0, acc, 1'b1, 64'h1F, 64'h1F);
    repeat (2) step(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0, acc);

    // Stall with a held input, then drain in order.
    cur = 1;
    repeat (3) begin
      step(1'b1, 32'hABCDE000 | cur, 3'd0, 5'(cur), 1'b0, 1'b0, acc);
      if (acc) cur++;
    end
    for (int n = 0; n < 10 && cur <= 3; n++) begin
      step(1'b1, 32'hABCDE000 | cur, 3'd0, 5'(cur), 1'b1, 1'b0, acc);
      if (acc) cur++;
    end
    repeat (3) step(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0, acc);

    // Flush while full, then resume.
    repeat (3) step(1'b1, 32'h00C00013, 3'd0, 5'd10, 1'b0, 1'b0, acc);
    step(1'b1, 32'h00D00013, 3'd0, 5'd11, 1'b0, 1'b1, acc);
    step(1'b1, 32'h00E00013, 3'd0, 5'd12, 1'b1, 1'b0, acc);
    repeat (2) step(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0, acc);

    // Asynchronous reset between edges with one entry held.
    step(1'b1, 32'hFFF00093, 3'd0, 5'd13, 1'b0, 1'b0, acc);
    step(1'b0, 32'h0, 3'd0, 5'd0, 1'b0, 1'b0, acc);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk_zero_outputs();
    q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel_ready32", 64'(rdy32), 64'h1);
    chk("rel_ready64", 64'(rdy64), 64'h1);
    step(1'b1, 32'h7FF00093, 3'd0, 5'd14, 1'b1, 1'b0, acc);
    step(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0, acc);

    // Random traffic.
    for (int n = 0; n < 120; n++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)), 5'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0), acc);
    end
    repeat (3) step(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0, acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32 and 64 only.
REQ-002 SHALL have parameter TAG_W, default 5, width of the sideband tag carried with each instruction.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-006 SHALL have port in_valid  input  1  upstream entry present.
REQ-007 SHALL have port in_ready  output  1  block accepts an entry this cycle.
REQ-008 SHALL have port in_instr  input  25  instruction bits [31:7].
REQ-009 SHALL have port in_immsrc  input  3  immediate format select.
REQ-010 SHALL have port in_tag  input  TAG_W  sideband, passed through unmodified.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port out_imm  output  XLEN  extended immediate.
REQ-014 SHALL have port out_err  output  1  in_immsrc was 3'b111.
REQ-015 SHALL have port out_tag  output  TAG_W  tag of the entry on out_imm.

Function
REQ-016 Formats (i = instruction bit, sx = sign-extend to XLEN from i31, zx = zero-extend): 000 I sx{i31:20}; 001 S sx{i31:25,i11:7}; 010 B sx{i31,i7,i30:25,i11:8,0}; 011 J sx{i31,i19:12,i20,i30:21,0}.
REQ-017 Format 100 U SHALL give {i31:12,12'b0}, sign-extended from i31 when XLEN=64.
REQ-018 Format 101 shamt SHALL give zx{i24:20} for XLEN=32, zx{i25:20} for XLEN=64.
REQ-019 Format 110 CSR zimm SHALL give zx{i19:15}.
REQ-020 Format 111 SHALL give out_imm all zeros with out_err=1; out_err=0 for all other formats.
REQ-021 Input transfer on in_valid && in_ready; output transfer on out_valid && out_ready; in_instr/in_immsrc/in_tag sampled only on input transfer.
REQ-022 Latency exactly 1 cycle: entry accepted at edge N is visible with out_valid=1 after edge N.
REQ-023 While out_valid && !out_ready, out_imm/out_err/out_tag SHALL stay stable.
REQ-024 Entries SHALL leave in acceptance order; no loss, no duplication.
REQ-025 flush=1 at an edge SHALL empty all entries (out_valid=0 after the edge); in_ready=0 while flush=1, so no entry is accepted that cycle.
REQ-026 Simultaneous input and output transfer at full occupancy is impossible (in_ready=0); at occupancy 1 it SHALL keep occupancy 1 with the new entry on the output.

Reset
REQ-027 reset assertion SHALL immediately clear all entries: out_valid=0, out_imm=0, out_err=0, out_tag=0, independent of clk.
REQ-028 in_ready SHALL be 1 while reset is deasserted and the block is empty and flush=0, including the first cycle after reset release; mid-transfer entries are discarded without acknowledgment.

Configuration
REQ-029 Macro IMM_GEN_PIPE_SKID_EN defined: 2-entry skid buffer with occupancy states EMPTY, ONE, TWO; in_ready driven from a register (1 in EMPTY/ONE, 0 in TWO); full throughput with registered ready.
REQ-030 Macro IMM_GEN_PIPE_SKID_EN undefined: single output register; in_ready = !flush && (!out_valid || out_ready) combinationally; all other requirements unchanged.

Verification
REQ-031 XLEN=32, immsrc 000, instr 0xFFF00093 -> out_imm 0xFFFFFFFF, out_err 0, one cycle later; immsrc 001, instr with i31:25=0x7F, i11:7=0x1C -> 0xFFFFFFFC.
REQ-032 XLEN=32, immsrc 010, instr 0x00000463 -> 0x00000008; immsrc 011, instr 0xFFDFF06F -> 0xFFFFFFFC; immsrc 111 -> 0x00000000, out_err 1.
REQ-033 XLEN=64, immsrc 100, instr 0x800000B7 -> 0xFFFFFFFF80000000; immsrc 101, instr 0x03F09093 -> 0x000000000000003F; immsrc 110, i19:15=5'h1F -> 0x1F.
REQ-034 SKID_EN, out_ready=0, in_valid=1 with tags 1,2,3 -> tags 1,2 accepted, in_ready=0 from next edge, tag 3 held; out_ready=1 -> outputs tags 1,2,3 in order on consecutive cycles, tag 1 stable throughout stall.
REQ-035 Occupancy TWO, flush=1 one cycle with in_valid=1 -> out_valid=0 after edge, in_ready=0 during flush, no entry accepted; next cycle entry accepted normally.
REQ-036 Occupancy ONE, reset asserted between edges -> out_valid=0, out_imm=0 immediately; after release in_ready=1 and first accepted entry appears after one cycle.
